regex_pc_fifo: RTL and testbench

- Thread queue feeding `regex_cpu`'s input PC port and absorbing its output PC port.
- Stores {cc_id, pc} thread entries in a circular buffer and replays them to the CPU in FIFO order.
- Split instructions emit two PCs back-to-back; those are queued here.
- A seed port lets the top level inject initial threads (e.g. PC 0 per character).

---
 rtl/regex_pc_fifo_if.sv | 39 +++
 rtl/regex_pc_fifo.sv | 73 +++++++
 tb/tb_regex_pc_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regex_pc_fifo_if.sv
// Handshake bundle between the thread queue and its producers (CPU, seed) and consumer (CPU input PC port).
// The slave modport is the queue side; the master modport is the CPU/top-level side.
interface regex_pc_fifo_if #(
  parameter int PC_WIDTH   = 9,
  parameter int CC_ID_BITS = 2
);
  logic                  cpu_in_valid;
  logic [CC_ID_BITS-1:0] cpu_in_cc_id;
  logic [PC_WIDTH-1:0]   cpu_in_pc;
  logic                  cpu_in_ready;

  logic                  seed_valid;
  logic [CC_ID_BITS-1:0] seed_cc_id;
  logic [PC_WIDTH-1:0]   seed_pc;
  logic                  seed_ready;

  logic                  out_valid;
  logic [CC_ID_BITS-1:0] out_cc_id;
  logic [PC_WIDTH-1:0]   out_pc;
  logic                  out_ready;

  modport slave (
    input  cpu_in_valid, cpu_in_cc_id, cpu_in_pc,
    output cpu_in_ready,
    input  seed_valid, seed_cc_id, seed_pc,
    output seed_ready,
    output out_valid, out_cc_id, out_pc,
    input  out_ready
  );

  modport master (
    output cpu_in_valid, cpu_in_cc_id, cpu_in_pc,
    input  cpu_in_ready,
    output seed_valid, seed_cc_id, seed_pc,
    input  seed_ready,
    input  out_valid, out_cc_id, out_pc,
    output out_ready
  );
endinterface

// File: rtl/regex_pc_fifo.sv
// Circular thread queue of {cc_id, pc} entries feeding regex_cpu; CPU pushes
// (split results) always win over seed injections so no split thread is dropped.
module regex_pc_fifo #(
  parameter int PC_WIDTH        = 9,
  parameter int CC_ID_BITS      = 2,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  regex_pc_fifo_if.slave           bus,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic                     empty,
  output logic                     full
);
  localparam int DEPTH   = 2 ** FIFO_ADDR_WIDTH;
  localparam int ENTRY_W = CC_ID_BITS + PC_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = DEPTH[FIFO_ADDR_WIDTH:0];

  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count_q;

  logic               cpu_push;
  logic               seed_push;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // Readiness is judged on pre-edge occupancy; a pop in a full cycle frees no slot yet.
  assign bus.cpu_in_ready = !full;
  assign bus.seed_ready   = !full && !bus.cpu_in_valid;

  assign cpu_push  = bus.cpu_in_valid && !full;
  assign seed_push = bus.seed_valid && !full && !bus.cpu_in_valid;
  assign push      = cpu_push || seed_push;
  assign pop       = !empty && bus.out_ready;

  assign wr_data = cpu_push ? {bus.cpu_in_cc_id, bus.cpu_in_pc}
                            : {bus.seed_cc_id, bus.seed_pc};

  assign head          = mem[rd_ptr];
  assign bus.out_valid = !empty;
  assign bus.out_cc_id = empty ? '0 : head[ENTRY_W-1:PC_WIDTH];
  assign bus.out_pc    = empty ? '0 : head[PC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; a push in a reset/flush cycle must not land.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: tb/tb_regex_pc_fifo.sv
// Directed bench for regex_pc_fifo: driver queues hand-computed expected entries,
// an independent monitor pops and compares on every accepted head transfer.
module tb_regex_pc_fifo;
  localparam int PW  = 9;
  localparam int CW  = 2;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  int total = 0;
  int bad   = 0;
  logic [CW+PW-1:0] sb [$];

  regex_pc_fifo_if #(.PC_WIDTH(PW), .CC_ID_BITS(CW)) bus ();

  regex_pc_fifo #(.PC_WIDTH(PW), .CC_ID_BITS(CW), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_in_valid = 1'b0;
    bus.cpu_in_cc_id = '0;
    bus.cpu_in_pc    = '0;
    bus.seed_valid   = 1'b0;
    bus.seed_cc_id   = '0;
    bus.seed_pc      = '0;
    bus.out_ready    = 1'b0;
  endtask

  task automatic cpu_drive(input logic [CW-1:0] cc, input logic [PW-1:0] pc);
    bus.cpu_in_valid = 1'b1;
    bus.cpu_in_cc_id = cc;
    bus.cpu_in_pc    = pc;
  endtask

  // Monitor: every head transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready && !rst && !flush) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        logic [CW+PW-1:0] e;
        e = sb.pop_front();
        chk("pop_cc", int'(bus.out_cc_id), int'(e[CW+PW-1:PW]));
        chk("pop_pc", int'(bus.out_pc), int'(e[PW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pc", int'(bus.out_pc), 0);
    chk("rst_out_cc", int'(bus.out_cc_id), 0);
    chk("rst_cpu_ready", int'(bus.cpu_in_ready), 1);
    chk("rst_seed_ready", int'(bus.seed_ready), 1);

    // Seed injection, no same-cycle bypass
    tick();
    bus.seed_valid = 1'b1; bus.seed_cc_id = 2'd2; bus.seed_pc = 9'h000;
    sb.push_back({2'd2, 9'h000});
    @(negedge clk);
    chk("seed_ready", int'(bus.seed_ready), 1);
    chk("no_bypass", int'(bus.out_valid), 0);
    tick();
    bus.seed_valid = 1'b0;
    @(negedge clk);
    chk("seed_out_valid", int'(bus.out_valid), 1);
    chk("seed_count", int'(count), 1);
    chk("seed_head_cc", int'(bus.out_cc_id), 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("seed_empty_after_pop", int'(empty), 1);

    // Split pair from CPU
    tick();
    cpu_drive(2'd1, 9'h06F); sb.push_back({2'd1, 9'h06F});
    tick();
    cpu_drive(2'd1, 9'h0C8); sb.push_back({2'd1, 9'h0C8});
    tick();
    idle();
    @(negedge clk);
    chk("split_count2", int'(count), 2);
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("split_count1", int'(count), 1);
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("split_count0", int'(count), 0);

    // CPU beats seed in the same cycle; seed lands next cycle
    tick();
    cpu_drive(2'd0, 9'h010);
    bus.seed_valid = 1'b1; bus.seed_cc_id = 2'd3; bus.seed_pc = 9'h020;
    sb.push_back({2'd0, 9'h010});
    @(negedge clk);
    chk("prio_seed_ready", int'(bus.seed_ready), 0);
    chk("prio_cpu_ready", int'(bus.cpu_in_ready), 1);
    tick();
    bus.cpu_in_valid = 1'b0;
    sb.push_back({2'd3, 9'h020});
    @(negedge clk);
    chk("prio_seed_ready_next", int'(bus.seed_ready), 1);
    tick();
    idle();
    @(negedge clk);
    chk("prio_count", int'(count), 2);
    bus.out_ready = 1'b1;
    tick(); tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("prio_drained", int'(count), 0);

    // Fill to 16, then 17th push with simultaneous pop is refused
    tick();
    for (int i = 0; i < 16; i++) begin
      cpu_drive(CW'(i % 4), PW'(i));
      sb.push_back({CW'(i % 4), PW'(i)});
      tick();
    end
    cpu_drive(2'd0, 9'h010);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("full_flag", int'(full), 1);
    chk("full_count", int'(count), 16);
    chk("full_cpu_ready", int'(bus.cpu_in_ready), 0);
    chk("full_seed_ready", int'(bus.seed_ready), 0);
    tick();
    idle();
    @(negedge clk);
    chk("full_after_count", int'(count), 15);
    chk("full_after_head", int'(bus.out_pc), 1);
    chk("full_after_flag", int'(full), 0);
    bus.out_ready = 1'b1;
    repeat (15) tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("full_drained", int'(count), 0);

    // Streaming 40 entries: pointers wrap, occupancy stays at most 1
    tick();
    for (int i = 0; i < 40; i++) begin
      cpu_drive(CW'((i + 1) % 4), PW'(i * 7 + 3));
      sb.push_back({CW'((i + 1) % 4), PW'(i * 7 + 3)});
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (i == 0) chk("stream_count_first", int'(count), 0);
      else if (i == 39) chk("stream_count_last", int'(count), 1);
      tick();
    end
    bus.cpu_in_valid = 1'b0;
    tick();
    idle();
    @(negedge clk);
    chk("stream_drained", int'(count), 0);

    // Flush (j=0) then rst (j=1) mid-operation with push and pop presented
    for (int j = 0; j < 2; j++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        cpu_drive(2'd2, PW'(9'h1A0 + i));
        tick();
      end
      idle();
      @(negedge clk);
      chk("load5_count", int'(count), 5);
      if (j == 0) flush = 1'b1; else rst = 1'b1;
      cpu_drive(2'd3, 9'h1FF);
      bus.out_ready = 1'b1;
      tick();
      flush = 1'b0;
      rst = 1'b0;
      idle();
      @(negedge clk);
      chk("clr_count", int'(count), 0);
      chk("clr_empty", int'(empty), 1);
      chk("clr_out_valid", int'(bus.out_valid), 0);
      chk("clr_out_pc", int'(bus.out_pc), 0);
      tick();
      cpu_drive(2'd1, PW'(9'h055 + j));
      sb.push_back({2'd1, PW'(9'h055 + j)});
      tick();
      idle();
      @(negedge clk);
      chk("clr_refill_count", int'(count), 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end

    @(negedge clk);
    chk("final_empty", int'(empty), 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
